freq_sweep_ctrl: RTL and testbench
==================================

# freq_sweep_ctrl

Sequencer that drives the NCO frequency word to produce stepped frequency sweeps (chirps) between two programmable endpoints. The block sits between the control/register front end and the phase accumulator, and owns that accumulator's `freq_word` input. When not sweeping, it forwards a static frequency. It supports single-shot, repeating and triangle (up/down) sweeps, plus pause and abort.

## Interface
- `FREQ_W`, 20, frequency word width in Hz units; matches the phase accumulator `freq_word`.
- `DWELL_W`, 24, width of the dwell counter (clk cycles per frequency step).
- `clk`  in  1  system clock (100 MHz domain).
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  one-cycle request to begin a sweep; ignored while `busy`.
- `abort`  in  1  terminate the sweep immediately; wins over `start` in the same cycle.
- `pause`  in  1  level; while high in RUN, freezes `freq_word` and the dwell count.
- `cfg_start_freq`  in  FREQ_W  sweep start frequency.
- `cfg_stop_freq`  in  FREQ_W  sweep stop frequency; may be below start, giving a down sweep.
- `cfg_step`  in  FREQ_W  step magnitude; 0 is treated as 1.
- `cfg_dwell`  in  DWELL_W  cycles held per frequency; 0 is treated as 1.
- `cfg_mode`  in  2  0 = single, 1 = repeat, 2 = triangle, 3 = reserved (behaves as single).
- `cfg_static_freq`  in  FREQ_W  frequency output while idle.
- `freq_word`  out  FREQ_W  registered frequency to the phase accumulator.
- `busy`  out  1  high in RUN and PAUSE.
- `dir`  out  1  current sweep direction; 1 = increasing.
- `step_pulse`  out  1  one cycle, high in the first cycle a new sweep frequency is presented.
- `sweep_done`  out  1  one cycle; the single sweep completed normally.

## Operation
- States:
  - IDLE: `freq_word <= cfg_static_freq` every cycle.
  - RUN: dwell counting.
  - PAUSE: frozen.
- IDLE, `start` with no `abort`:
  - Latch all `cfg_*` into shadow registers.
  - `freq_word <= start`.
  - `dir <= (stop >= start)`.
  - Dwell counter loads `max(dwell, 1) - 1`.
  - Go to RUN; `step_pulse` asserts.
  - Mid-sweep `cfg_*` changes have no effect until the next start.
- RUN, counter != 0: decrement.
- RUN, counter == 0: the current frequency has been held exactly `max(dwell, 1)` cycles.
  - Not at the far endpoint: next = current ± step, computed at FREQ_W+1 bits and clamped to the endpoint if it would pass it or overflow/underflow. Reload the counter; `step_pulse` asserts.
  - At the stop endpoint, single/reserved mode: go to IDLE, `sweep_done` = 1, `freq_word <= cfg_static_freq`.
  - At the stop endpoint, repeat mode: `freq_word <= start`, `dir` unchanged, `step_pulse` asserts.
  - Triangle mode, at either endpoint: toggle `dir` and step toward the other endpoint (clamped); `step_pulse` asserts.
  - Triangle mode, start == stop: frequency stays constant and `step_pulse` asserts every dwell period.
- The far endpoint is the stop frequency, except in triangle mode while returning toward start.
- start == stop, single mode: exactly one dwell period at that frequency, then done.
- RUN with `pause`: go to PAUSE; all registers hold. PAUSE with `!pause`: return to RUN and resume the count where it stopped.
- `abort` in RUN or PAUSE: next state is IDLE, `freq_word <= cfg_static_freq`, `busy` = 0, no `sweep_done`.
- `abort` and `start` together in IDLE: stay in IDLE.
- Priority: `rst_n` > `abort` > `pause` > dwell expiry.

## Timing
- Reset (`rst_n` low at an edge) sets:
  - state IDLE;
  - `freq_word` = 0, `busy` = 0, `dir` = 0, `step_pulse` = 0, `sweep_done` = 0;
  - counter = 0.
- The first IDLE cycle after reset loads `cfg_static_freq`.
- `start` sampled at edge N → `freq_word` = start and `busy` = 1 visible after edge N.
- Each sweep frequency is visible for exactly `max(dwell, 1)` cycles, excluding paused cycles.
- `sweep_done` rises on the same edge at which `busy` falls and `freq_word` returns to static.
- `pause` and `abort` act on the edge at which they are sampled (1-cycle latency).
- Reset mid-sweep has the same effect as reset from IDLE; no `sweep_done` is emitted.

## Structure
- Package `sweep_pkg`:
  - state enum (IDLE, RUN, PAUSE);
  - mode encodings (MODE_SINGLE, MODE_REPEAT, MODE_TRIANGLE);
  - FREQ_W and DWELL_W defaults.
- Sub-module `dwell_timer`: loadable down-counter with `load`, `value`, `en` and an `expired` flag. `en` is low during pause.
- Next-frequency add/sub/clamp logic stays in the top FSM as one combinational block.

## Test plan
- Single up sweep: start = 1000, stop = 1040, step = 10, dwell = 3, mode 0 → 1000, 1010, 1020, 1030, 1040, each held 3 cycles. Expect 5 `step_pulse`, `busy` high for 15 cycles, then `sweep_done` with `freq_word` = static.
- Clamp: start = 100, stop = 125, step = 10, dwell = 1 → 100, 110, 120, 125, then done.
- Clamp at full scale: start = 1048570, stop = 1048575, step = 10 → 1048570, 1048575.
- Triangle: start = 500, stop = 520, step = 10, dwell = 1 → 500, 510, 520, 510, 500, 510… `dir` toggles at 520 and at 500. Expect no `sweep_done` over 20 cycles.
- Down repeat: start = 200, stop = 180, step = 10, dwell = 2, mode 1 → `dir` = 0; 200, 190, 180, 200, 190… Changing `cfg_step` mid-sweep has no effect.
- Pause/abort:
  - `pause` for 5 cycles mid-dwell extends that frequency by exactly 5 cycles.
  - `abort` → IDLE next edge, `freq_word` = static, no done.
  - `start` + `abort` together → stays IDLE.
  - `start` while `busy` is ignored.
- Reset: `rst_n` low for 1 cycle mid-sweep → all outputs at reset values, then static follows.
- Reset: dwell = 0 and step = 0 → behave as 1.

Source files
------------

// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types, mode encodings and default widths for the frequency sweep controller.
package sweep_pkg;
    localparam int DEF_FREQ_W  = 20;
    localparam int DEF_DWELL_W = 24;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    localparam logic [1:0] MODE_SINGLE   = 2'd0;
    localparam logic [1:0] MODE_REPEAT   = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: loadable down-counter that flags expiry when it reaches zero.
module dwell_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         expired
);
    logic [W-1:0] count_q, count_d;
    always_comb begin
        count_d = load ? value : (en && count_q != '0) ? count_q - 1'b1 : count_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end
    assign expired = count_q == '0;
endmodule

// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: stepped single/repeat/triangle frequency sweeps feeding the NCO freq_word,
// with pause and abort; forwards the static frequency while idle.
module freq_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int FREQ_W  = DEF_FREQ_W,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic [FREQ_W-1:0]  cfg_start_freq,
    input  logic [FREQ_W-1:0]  cfg_stop_freq,
    input  logic [FREQ_W-1:0]  cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic [FREQ_W-1:0]  cfg_static_freq,
    output logic [FREQ_W-1:0]  freq_word,
    output logic               busy,
    output logic               dir,
    output logic               step_pulse,
    output logic               sweep_done
);
    state_t             state_q, state_d;
    logic [FREQ_W-1:0]  start_q, start_d, stop_q, stop_d, step_q, step_d;
    logic [DWELL_W-1:0] reload_q, reload_d;
    logic [1:0]         mode_q, mode_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic               dir_q, dir_d, pulse_q, pulse_d, done_q, done_d;
    logic go, active, expired, adv, finish, tri_m, up0, at_end, dir_n;
    logic [FREQ_W-1:0]  tgt, tgt_n, stepped, dwell_val;
    logic [FREQ_W:0]    sum, diff;
    logic [DWELL_W-1:0] timer_val;

    assign go      = state_q == IDLE && start && !abort;
    // A PAUSE cycle with pause released counts like RUN, so a 5-cycle pause costs exactly 5 cycles.
    assign active  = state_q != IDLE && !abort && !pause;
    assign tri_m   = mode_q == MODE_TRIANGLE;
    assign up0     = stop_q >= start_q;
    assign tgt     = (tri_m && dir_q != up0) ? start_q : stop_q;
    assign at_end  = freq_q == tgt;
    assign finish  = active && expired && at_end && !tri_m && mode_q != MODE_REPEAT;
    assign adv     = active && expired && !finish;
    assign timer_val = go ? ((cfg_dwell == '0) ? '0 : cfg_dwell - 1'b1) : reload_q;

    dwell_timer #(.W(DWELL_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (go || adv),
        .en      (active),
        .value   (timer_val),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            reload_q <= '0;
            mode_q   <= MODE_SINGLE;
            freq_q   <= '0;
            dir_q    <= 1'b0;
            pulse_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            step_q   <= step_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            freq_q   <= freq_d;
            dir_q    <= dir_d;
            pulse_q  <= pulse_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = go ? RUN : IDLE;
        else if (abort || finish) state_d = IDLE;
        else if (pause) state_d = PAUSE;
        else state_d = RUN;
    end

    always_comb begin
        dwell_val = '0;
        start_d  = go ? cfg_start_freq : start_q;
        stop_d   = go ? cfg_stop_freq : stop_q;
        step_d   = go ? ((cfg_step == '0) ? FREQ_W'(1) : cfg_step) : step_q;
        reload_d = go ? timer_val : reload_q;
        mode_d   = go ? cfg_mode : mode_q;
        // Triangle turns around at either endpoint, then heads for the opposite one.
        dir_n    = (tri_m && at_end) ? !dir_q : dir_q;
        tgt_n    = (tri_m && dir_n != up0) ? start_q : stop_q;
        sum      = {1'b0, freq_q} + {1'b0, step_q};
        diff     = {1'b0, freq_q} - {1'b0, step_q};
        stepped  = dir_n ? ((sum > {1'b0, tgt_n}) ? tgt_n : sum[FREQ_W-1:0])
                         : ((diff[FREQ_W] || diff[FREQ_W-1:0] < tgt_n) ? tgt_n : diff[FREQ_W-1:0]);
        freq_d   = (state_q == IDLE) ? (go ? cfg_start_freq : cfg_static_freq)
                 : (abort || finish) ? cfg_static_freq
                 : !adv ? freq_q
                 : (at_end && mode_q == MODE_REPEAT) ? start_q : stepped;
        dir_d    = go ? (cfg_stop_freq >= cfg_start_freq) : adv ? dir_n : dir_q;
        pulse_d  = go || adv;
        done_d   = finish;
    end

    assign freq_word  = freq_q;
    assign busy       = state_q != IDLE;
    assign dir        = dir_q;
    assign step_pulse = pulse_q;
    assign sweep_done = done_q;
endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// tb_freq_sweep_ctrl: directed self-checking bench for freq_sweep_ctrl.
module tb_freq_sweep_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, start, abort, pause;
    logic [19:0] cfg_start_freq, cfg_stop_freq, cfg_step, cfg_static_freq;
    logic [23:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic [19:0] freq_word;
    logic        busy, dir, step_pulse, sweep_done;
    int checks = 0;
    int failures = 0;
    int pulses;

    freq_sweep_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
        .cfg_start_freq(cfg_start_freq), .cfg_stop_freq(cfg_stop_freq), .cfg_step(cfg_step),
        .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_static_freq(cfg_static_freq),
        .freq_word(freq_word), .busy(busy), .dir(dir), .step_pulse(step_pulse),
        .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic setcfg(input int s, input int e, input int st, input int dw, input int m);
        cfg_start_freq = 20'(s);
        cfg_stop_freq  = 20'(e);
        cfg_step       = 20'(st);
        cfg_dwell      = 24'(dw);
        cfg_mode       = 2'(m);
    endtask

    task automatic chk_idle_done(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, sweep_done, 1);
        chk({tag, "_freq"}, freq_word, 12345);
        tick();
        chk({tag, "_done_clr"}, sweep_done, 0);
    endtask

    initial begin
        rst_n = 0; start = 0; abort = 0; pause = 0;
        cfg_static_freq = 20'd12345;
        setcfg(0, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        chk("rst_freq", freq_word, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dir", dir, 0);
        chk("rst_pulse", step_pulse, 0);
        chk("rst_done", sweep_done, 0);
        rst_n = 1;
        tick();
        chk("idle_static", freq_word, 12345);
        chk("idle_busy", busy, 0);

        // single up sweep
        setcfg(1000, 1040, 10, 3, 0);
        go();
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            chk("up_freq", freq_word, 1000 + 10 * (i / 3));
            chk("up_pulse", step_pulse, (i % 3 == 0) ? 1 : 0);
            chk("up_busy", busy, 1);
            chk("up_dir", dir, 1);
            chk("up_done", sweep_done, 0);
            pulses += int'(step_pulse);
            tick();
        end
        chk("up_npulse", pulses, 5);
        chk_idle_done("up_end");

        // clamp at stop
        setcfg(100, 125, 10, 1, 0);
        go();
        chk("clamp_f0", freq_word, 100); tick();
        chk("clamp_f1", freq_word, 110); tick();
        chk("clamp_f2", freq_word, 120); tick();
        chk("clamp_f3", freq_word, 125);
        chk("clamp_p3", step_pulse, 1); tick();
        chk_idle_done("clamp_end");

        // clamp at full scale
        setcfg(1048570, 1048575, 10, 1, 0);
        go();
        chk("fs_f0", freq_word, 1048570); tick();
        chk("fs_f1", freq_word, 1048575); tick();
        chk_idle_done("fs_end");

        // triangle
        setcfg(500, 520, 10, 1, 2);
        go();
        for (int i = 0; i < 20; i++) begin
            chk("tri_freq", freq_word, (i % 4 == 0) ? 500 : (i % 4 == 2) ? 520 : 510);
            chk("tri_dir", dir, (i == 0) ? 1 : (i % 4 == 1 || i % 4 == 2) ? 1 : 0);
            chk("tri_pulse", step_pulse, 1);
            chk("tri_done", sweep_done, 0);
            tick();
        end
        abort = 1;
        tick();
        abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_freq", freq_word, 12345);
        chk("abort_done", sweep_done, 0);

        // down repeat with mid-sweep cfg change
        setcfg(200, 180, 10, 2, 1);
        go();
        for (int i = 0; i < 14; i++) begin
            if (i == 3) cfg_step = 20'd50;
            chk("rep_freq", freq_word, (i % 6 < 2) ? 200 : (i % 6 < 4) ? 190 : 180);
            chk("rep_dir", dir, 0);
            chk("rep_pulse", step_pulse, (i % 2 == 0) ? 1 : 0);
            chk("rep_done", sweep_done, 0);
            tick();
        end
        abort = 1;
        tick();
        abort = 0;
        chk("rep_abort_busy", busy, 0);

        // pause extends the current frequency by the paused cycles
        setcfg(1000, 1040, 10, 3, 0);
        go();
        chk("pz_f0", freq_word, 1000);
        tick();
        chk("pz_f1", freq_word, 1000);
        pause = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pz_hold", freq_word, 1000);
            chk("pz_busy", busy, 1);
        end
        pause = 0;
        tick();
        chk("pz_resume", freq_word, 1000);
        tick();
        chk("pz_next", freq_word, 1010);
        chk("pz_next_pulse", step_pulse, 1);
        // start while busy is ignored
        cfg_start_freq = 20'd7777;
        start = 1;
        tick();
        start = 0;
        chk("busy_start_freq", freq_word, 1010);
        chk("busy_start_pulse", step_pulse, 0);
        abort = 1;
        tick();
        abort = 0;
        chk("pz_abort_busy", busy, 0);
        chk("pz_abort_freq", freq_word, 12345);
        chk("pz_abort_done", sweep_done, 0);
        // start + abort together in idle
        start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        chk("sa_busy", busy, 0);
        chk("sa_freq", freq_word, 12345);
        chk("sa_pulse", step_pulse, 0);

        // reset mid-sweep
        setcfg(400, 300, 10, 2, 0);
        go();
        tick(); tick();
        chk("mid_dir", dir, 0);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("mrst_freq", freq_word, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_dir", dir, 0);
        chk("mrst_pulse", step_pulse, 0);
        chk("mrst_done", sweep_done, 0);
        tick();
        chk("mrst_static", freq_word, 12345);
        chk("mrst_done2", sweep_done, 0);

        // zero dwell and zero step behave as 1
        setcfg(300, 302, 0, 0, 0);
        go();
        chk("z_f0", freq_word, 300); tick();
        chk("z_f1", freq_word, 301); tick();
        chk("z_f2", freq_word, 302); tick();
        chk_idle_done("z_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
